// File: rtl/ddr_app_pkg.sv
// rtl/ddr_app_pkg.sv - shared constants and command classification for the MIG app responder
package ddr_app_pkg;

   localparam int DDR_DATA_WIDTH = 128;
   localparam int DDR_ADDR_WIDTH = 28;
   localparam int DDR_MASK_WIDTH = DDR_DATA_WIDTH / 8;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   // What the command-queue head does this cycle
   typedef enum logic [1:0] {
      EXEC_IDLE    = 2'd0,
      EXEC_READ    = 2'd1,
      EXEC_WRITE   = 2'd2,
      EXEC_ILLEGAL = 2'd3
   } exec_kind_e;

   // A write at the head stalls (IDLE) until its data beat is queued
   function automatic exec_kind_e classify_head(input logic       head_valid,
                                                input logic [2:0] head_cmd,
                                                input logic       wdf_avail);
      exec_kind_e kind;
      kind = EXEC_IDLE;
      if (head_valid) begin
         if (head_cmd == CMD_READ)
            kind = EXEC_READ;
         else if (head_cmd == CMD_WRITE)
            kind = wdf_avail ? EXEC_WRITE : EXEC_IDLE;
         else
            kind = EXEC_ILLEGAL;
      end
      return kind;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, power-of-2 depth >= 2
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage is not reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mig_app_responder.sv
// rtl/mig_app_responder.sv - on-chip memory model answering the MIG 7-series app interface
module mig_app_responder #(
   parameter int DDR_DATA_WIDTH = ddr_app_pkg::DDR_DATA_WIDTH,
   parameter int DDR_ADDR_WIDTH = ddr_app_pkg::DDR_ADDR_WIDTH,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int CALIB_CYCLES   = 64,
   parameter int RD_LATENCY     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int RDY_THROTTLE   = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        app_en,
   input  logic [2:0]                  app_cmd,
   input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
   output logic                        app_rdy,
   input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
   input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                        app_wdf_wren,
   input  logic                        app_wdf_end,
   output logic                        app_wdf_rdy,
   output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
   output logic                        app_rd_data_valid,
   output logic                        app_rd_data_end,
   output logic                        init_calib_complete,
   output logic                        proto_err
);

   import ddr_app_pkg::*;

   localparam int MASK_W = DDR_DATA_WIDTH / 8;
   localparam int CMD_W  = 3 + MEM_DEPTH_LOG2;
   localparam int WDF_W  = MASK_W + DDR_DATA_WIDTH;
   localparam logic [31:0] CALIB_LAST = 32'(CALIB_CYCLES - 1);
   localparam logic [15:0] THR_LAST   = 16'(RDY_THROTTLE - 1);

   logic                      calib_done;
   logic [31:0]               calib_cnt;
   logic [15:0]               thr_cnt;
   logic                      throttle_slot;

   logic                      cmd_push;
   logic                      cmd_pop;
   logic                      cmd_full;
   logic                      cmd_empty;
   logic [CMD_W-1:0]          cmd_head;
   logic                      wdf_push;
   logic                      wdf_pop;
   logic                      wdf_full;
   logic                      wdf_empty;
   logic [WDF_W-1:0]          wdf_head;

   logic [2:0]                head_cmd;
   logic [MEM_DEPTH_LOG2-1:0] head_idx;
   logic [MASK_W-1:0]         head_mask;
   logic [DDR_DATA_WIDTH-1:0] head_data;
   exec_kind_e                kind;

   logic [DDR_DATA_WIDTH-1:0] ram [2**MEM_DEPTH_LOG2];
   logic [DDR_DATA_WIDTH-1:0] ram_q;
   logic                      ram_v;
   logic [RD_LATENCY-1:0]     pipe_v;
   logic [DDR_DATA_WIDTH-1:0] pipe_d [RD_LATENCY];

   // Address bits outside the word index are deliberately ignored (memory wraps)
   logic                      unused_addr_bits;
   assign unused_addr_bits = ^{app_addr[DDR_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app_addr[2:0]};

   assign init_calib_complete = calib_done;
   assign throttle_slot       = (RDY_THROTTLE > 0) && (thr_cnt == THR_LAST);
   assign app_rdy             = calib_done && !cmd_full && !throttle_slot;
   assign app_wdf_rdy         = calib_done && !wdf_full;
   assign cmd_push            = app_en && app_rdy;
   assign wdf_push            = app_wdf_wren && app_wdf_rdy;

   assign head_cmd  = cmd_head[CMD_W-1 -: 3];
   assign head_idx  = cmd_head[MEM_DEPTH_LOG2-1:0];
   assign head_mask = wdf_head[WDF_W-1 -: MASK_W];
   assign head_data = wdf_head[DDR_DATA_WIDTH-1:0];
   assign kind      = classify_head(!cmd_empty, head_cmd, !wdf_empty);
   assign cmd_pop   = (kind != EXEC_IDLE);
   assign wdf_pop   = (kind == EXEC_WRITE);

   assign app_rd_data       = pipe_d[RD_LATENCY-1];
   assign app_rd_data_valid = pipe_v[RD_LATENCY-1];
   assign app_rd_data_end   = pipe_v[RD_LATENCY-1];

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (cmd_push),
      .push_data ({app_cmd, app_addr[MEM_DEPTH_LOG2+2:3]}),
      .pop       (cmd_pop),
      .pop_data  (cmd_head),
      .full      (cmd_full),
      .empty     (cmd_empty)
   );

   sync_fifo #(.WIDTH(WDF_W), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (wdf_push),
      .push_data ({app_wdf_mask, app_wdf_data}),
      .pop       (wdf_pop),
      .pop_data  (wdf_head),
      .full      (wdf_full),
      .empty     (wdf_empty)
   );

   // Calibration timer: done at the CALIB_CYCLES-th edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         calib_cnt  <= '0;
         calib_done <= 1'b0;
      end else if (!calib_done) begin
         calib_cnt <= calib_cnt + 32'd1;
         if (calib_cnt == CALIB_LAST)
            calib_done <= 1'b1;
      end
   end

   // Free-running throttle counter, modulo RDY_THROTTLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         thr_cnt <= '0;
      else if (RDY_THROTTLE > 0)
         thr_cnt <= (thr_cnt == THR_LAST) ? '0 : thr_cnt + 16'd1;
   end

   // Block RAM with byte enables; a set mask bit preserves that byte
   always_ff @(posedge clk) begin
      if (kind == EXEC_WRITE) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!head_mask[b])
               ram[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
         end
      end
      if (kind == EXEC_READ)
         ram_q <= ram[head_idx];
   end

   // Read pipeline: RAM output register followed by RD_LATENCY shift stages
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_v  <= 1'b0;
         pipe_v <= '0;
         for (int i = 0; i < RD_LATENCY; i++)
            pipe_d[i] <= '0;
      end else begin
         ram_v     <= (kind == EXEC_READ);
         pipe_v[0] <= ram_v;
         pipe_d[0] <= ram_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   // Sticky protocol error: illegal command, wren/end mismatch, traffic before calibration
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         proto_err <= 1'b0;
      else if ((kind == EXEC_ILLEGAL) ||
               (app_wdf_end != app_wdf_wren) ||
               (!calib_done && (app_en || app_wdf_wren)))
         proto_err <= 1'b1;
   end

endmodule

// File: tb/tb_mig_app_responder.sv
// tb/tb_mig_app_responder.sv - randomized scoreboard bench for mig_app_responder
module tb_mig_app_responder;

   localparam int DW    = 128;
   localparam int AW    = 28;
   localparam int MW    = DW / 8;
   localparam int CALIB = 64;
   localparam int LAT   = 8;
   localparam int THR   = 4;
   localparam int BOUND = 2000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          app_en = 1'b0;
   logic [2:0]    app_cmd = 3'b000;
   logic [AW-1:0] app_addr = '0;
   logic          app_rdy;
   logic [DW-1:0] app_wdf_data = '0;
   logic [MW-1:0] app_wdf_mask = '0;
   logic          app_wdf_wren = 1'b0;
   logic          app_wdf_end = 1'b0;
   logic          app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          app_rd_data_end;
   logic          init_calib_complete;
   logic          proto_err;

   always #5 clk = ~clk;

   mig_app_responder #(
      .DDR_DATA_WIDTH (DW),
      .DDR_ADDR_WIDTH (AW),
      .MEM_DEPTH_LOG2 (10),
      .CALIB_CYCLES   (CALIB),
      .RD_LATENCY     (LAT),
      .FIFO_DEPTH     (4),
      .RDY_THROTTLE   (THR)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .app_en              (app_en),
      .app_cmd             (app_cmd),
      .app_addr            (app_addr),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .init_calib_complete (init_calib_complete),
      .proto_err           (proto_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input bit ok, input string name,
                                 input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // Reference model: commands and data beats are matched strictly in issue order
   typedef struct { bit rd; bit bad; int idx; } cmd_t;
   cmd_t          ord_q[$];
   logic [DW-1:0] wd_data_q[$];
   logic [MW-1:0] wd_mask_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mem_m [int];

   function automatic void model_run();
      logic [DW-1:0] w;
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      while (ord_q.size() > 0) begin
         if (ord_q[0].bad) begin
            void'(ord_q.pop_front());
         end else if (ord_q[0].rd) begin
            exp_q.push_back(mem_m.exists(ord_q[0].idx) ? mem_m[ord_q[0].idx] : '0);
            void'(ord_q.pop_front());
         end else if (wd_data_q.size() > 0) begin
            d = wd_data_q.pop_front();
            m = wd_mask_q.pop_front();
            w = mem_m.exists(ord_q[0].idx) ? mem_m[ord_q[0].idx] : '0;
            for (int b = 0; b < MW; b++)
               if (!m[b]) w[b*8 +: 8] = d[b*8 +: 8];
            mem_m[ord_q[0].idx] = w;
            void'(ord_q.pop_front());
         end else begin
            break;
         end
      end
   endfunction

   function automatic void model_clear();
      ord_q.delete();
      wd_data_q.delete();
      wd_mask_q.delete();
      exp_q.delete();
   endfunction

   function automatic logic [AW-1:0] rand_addr(input int idx);
      logic [AW-1:0] a;
      a = AW'($urandom());
      a[12:3] = 10'(idx);
      return a;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Edges since reset release
   int edges;
   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   // Monitor: pops the scoreboard on every read valid, plus calibration/throttle rules
   int            n_valid = 0;
   logic [DW-1:0] mon_e;
   always @(negedge clk) begin
      if (rst) begin
         check(init_calib_complete == (edges >= CALIB), "calib_level", init_calib_complete, edges >= CALIB);
         if (edges < CALIB)
            check(!app_rdy && !app_wdf_rdy, "rdy_before_calib", {app_rdy, app_wdf_rdy}, 0);
         if (edges >= CALIB && (edges % THR) == THR - 1)
            check(!app_rdy, "throttle_slot", app_rdy, 0);
         check(app_rd_data_end == app_rd_data_valid, "rd_end", app_rd_data_end, app_rd_data_valid);
         if (app_rd_data_valid) begin
            n_valid++;
            check(exp_q.size() != 0, "unexpected_valid", app_rd_data, 0);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check(app_rd_data == mon_e, "rd_data", app_rd_data, mon_e);
            end
         end
      end
   end

   task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
      int   n;
      cmd_t e;
      app_en = 1'b1; app_cmd = c; app_addr = a; n = 0;
      while (!app_rdy && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check(n < BOUND, "cmd_accept_timeout", n, BOUND);
      @(posedge clk);
      @(negedge clk);
      app_en = 1'b0;
      e.rd  = (c == 3'b001);
      e.bad = (c != 3'b000) && (c != 3'b001);
      e.idx = int'(a[12:3]);
      ord_q.push_back(e);
      model_run();
   endtask

   task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m);
      int n;
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m; n = 0;
      while (!app_wdf_rdy && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check(n < BOUND, "wdf_accept_timeout", n, BOUND);
      @(posedge clk);
      @(negedge clk);
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      wd_data_q.push_back(d);
      wd_mask_q.push_back(m);
      model_run();
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      model_clear();
      app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      repeat (3) @(negedge clk);
      check({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete, proto_err} == 6'b0,
            "reset_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete, proto_err}, 0);
      check(app_rd_data == '0, "reset_rd_data", app_rd_data, 0);
   endtask

   task automatic release_and_calibrate();
      rst = 1'b1;
      repeat (CALIB - 1) @(negedge clk);
      check(!init_calib_complete && !app_rdy, "calib_low_at_63", {init_calib_complete, app_rdy}, 0);
      @(negedge clk);
      check(init_calib_complete, "calib_high_at_64", init_calib_complete, 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || ord_q.size() > 0) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check(exp_q.size() == 0 && ord_q.size() == 0, "drain", exp_q.size(), 0);
   endtask

   bit            full_seen;
   bit            op_rd [100];
   int            op_idx [100];
   logic [DW-1:0] wr_d [100];
   logic [MW-1:0] wr_m [100];
   int            nw;
   int            k;
   int            valid_snap;
   logic [DW-1:0] da;
   logic [DW-1:0] db;

   initial begin
      assert_reset();
      release_and_calibrate();

      // Known contents for words 0..7 so random reads are always defined
      for (int i = 0; i < 8; i++) begin
         send_cmd(3'b000, rand_addr(i));
         send_wdf(rand_data(), '0);
      end
      wait_drain();

      // Write then read 0x10: latency from accept to valid
      send_cmd(3'b000, 28'h10);
      send_wdf(128'h0123456789ABCDEF0123456789ABCDEF, '0);
      repeat (5) @(negedge clk);
      send_cmd(3'b001, 28'h10);
      k = 0;
      while (!app_rd_data_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check(k == LAT + 1, "read_latency", k, LAT + 1);
      check(app_rd_data == 128'h0123456789ABCDEF0123456789ABCDEF, "rd_0x10", app_rd_data,
            128'h0123456789ABCDEF0123456789ABCDEF);
      wait_drain();

      // Byte-masked overwrite of 0x20
      da = rand_data();
      db = rand_data();
      send_cmd(3'b000, 28'h20);
      send_wdf(da, '0);
      send_cmd(3'b000, 28'h20);
      send_wdf(db, 16'h00FF);
      send_cmd(3'b001, 28'h20);
      k = 0;
      while (!app_rd_data_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check(app_rd_data == {db[127:64], da[63:0]}, "masked_merge", app_rd_data, {db[127:64], da[63:0]});
      wait_drain();

      // Four writes with late data fill the command FIFO; reads follow in order
      full_seen = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send_cmd(3'b000, rand_addr(8 + i));
            check(!app_rdy, "cmd_full_rdy_low", app_rdy, 0);
            full_seen = 1'b1;
            for (int i = 0; i < 4; i++) send_cmd(3'b001, rand_addr(8 + i));
         end
         begin
            wait (full_seen);
            repeat (3) @(negedge clk);
            for (int i = 0; i < 4; i++) send_wdf(rand_data(), '0);
         end
      join
      wait_drain();

      // 100 random commands with independently timed write data
      nw = 0;
      for (int i = 0; i < 100; i++) begin
         op_rd[i]  = ($urandom_range(0, 1) == 1);
         op_idx[i] = $urandom_range(0, 7);
         if (!op_rd[i]) begin
            wr_d[nw] = rand_data();
            wr_m[nw] = MW'($urandom());
            nw++;
         end
      end
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send_cmd(op_rd[i] ? 3'b001 : 3'b000, rand_addr(op_idx[i]));
            end
         end
         begin
            for (int j = 0; j < nw; j++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send_wdf(wr_d[j], wr_m[j]);
            end
         end
      join
      wait_drain();
      check(!proto_err, "no_err_legal_traffic", proto_err, 0);

      // Illegal command sets the sticky error
      send_cmd(3'b111, rand_addr(3));
      repeat (3) @(negedge clk);
      check(proto_err, "err_illegal_cmd", proto_err, 1);

      // Command before calibration
      assert_reset();
      rst = 1'b1;
      repeat (10) @(negedge clk);
      app_en = 1'b1; app_cmd = 3'b001;
      @(negedge clk);
      app_en = 1'b0;
      @(negedge clk);
      check(proto_err, "err_before_calib", proto_err, 1);

      // wren without end
      assert_reset();
      release_and_calibrate();
      check(!proto_err, "err_clear_after_reset", proto_err, 0);
      app_wdf_wren = 1'b1; app_wdf_end = 1'b0;
      @(negedge clk);
      app_wdf_wren = 1'b0;
      @(negedge clk);
      check(proto_err, "err_wren_end", proto_err, 1);
      repeat (10) @(negedge clk);
      check(proto_err, "err_sticky", proto_err, 1);

      // Asynchronous reset with reads in flight
      assert_reset();
      release_and_calibrate();
      for (int i = 0; i < 3; i++) send_cmd(3'b001, rand_addr(i));
      repeat (2) @(negedge clk);
      valid_snap = n_valid;
      #3 rst = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (LAT + 20) @(negedge clk);
      check(n_valid == valid_snap, "no_valid_after_reset", n_valid, valid_snap);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
